// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write-back path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // One queued register-file write
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wr;
        logic [DATA_W-1:0] wd;
    } rf_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Generic DEPTH-entry FIFO of register writes with per-entry valid/dest vectors exposed.
// Latency: a push at edge N is visible at the head from cycle N+1; head data is combinational.
// Backpressure: push ignored while full, pop ignored while empty; caller derives ready from full.
//
// Ports: clk/rst_n (async active-low); push/push_wr/push_wd enqueue; pop dequeues the head;
// head_wr/head_wd raw head contents; count/full/empty occupancy; vld_vec/wr_vec per-slot
// valid and destination. With RF_WB_FORWARD_EN defined, ents (all slots) and rd_ptr are
// also exported for the forwarding lookup.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [REG_AW-1:0]              push_wr,
    input  logic [DATA_W-1:0]              push_wd,
    input  logic                           pop,
    output logic [REG_AW-1:0]              head_wr,
    output logic [DATA_W-1:0]              head_wd,
    output logic [AW:0]                    count,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH-1:0]               vld_vec,
    output logic [DEPTH-1:0][REG_AW-1:0]   wr_vec
`ifdef RF_WB_FORWARD_EN
    ,
    output rf_entry_t [DEPTH-1:0]          ents,
    output logic [AW-1:0]                  rd_ptr
`endif
);

    rf_entry_t [DEPTH-1:0] slots;
    logic [AW-1:0]         wr_p;
    logic [AW-1:0]         rd_p;
    logic [AW:0]           cnt;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;
    assign head_wr = slots[rd_p].wr;
    assign head_wd = slots[rd_p].wd;

`ifdef RF_WB_FORWARD_EN
    assign ents   = slots;
    assign rd_ptr = rd_p;
`endif

    always_comb begin
        vld_vec = '0;
        wr_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_vec[i] = slots[i].valid;
            wr_vec[i]  = slots[i].wr;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
    // A pop and a push never address the same slot: a pop needs a non-empty
    // queue and a push needs a non-full one, so wr_p != rd_p whenever both fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
            wr_p  <= '0;
            rd_p  <= '0;
            cnt   <= '0;
        end else begin
            if (do_pop) begin
                slots[rd_p].valid <= 1'b0;
                rd_p              <= rd_p + AW'(1);
            end
            if (do_push) begin
                slots[wr_p] <= '{valid: 1'b1, wr: push_wr, wd: push_wd};
                wr_p        <= wr_p + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// Write-back front end: arbitrates ALU/load results into a FIFO and retires one RF write per cycle.
// Latency: result accepted at edge N drives rf_* in cycle N+1 and is written at edge N+1.
// Backpressure: loads win; mem_ready = !full, alu_ready = !full && !mem_valid.
//
// Ports: clk, rst_n (async active-low); alu_valid/alu_ready/alu_wr/alu_wd and
// mem_valid/mem_ready/mem_wr/mem_wd producer handshakes; rf_wr/rf_wd/rf_we drive the
// register file write port; pend_mask is the in-flight destination scoreboard;
// count/full/empty report occupancy.
// Optional: define RF_WB_FORWARD_EN to add fwd_rr/fwd_hit/fwd_data, a combinational
// lookup returning the youngest queued data for a register.
module rf_writeback_queue
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_AW-1:0]   alu_wr,
    input  logic [DATA_W-1:0]   alu_wd,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_AW-1:0]   mem_wr,
    input  logic [DATA_W-1:0]   mem_wd,
    output logic [REG_AW-1:0]   rf_wr,
    output logic [DATA_W-1:0]   rf_wd,
    output logic                rf_we,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic [AW:0]         count,
    output logic                full,
    output logic                empty
`ifdef RF_WB_FORWARD_EN
    ,
    input  logic [REG_AW-1:0]   fwd_rr,
    output logic                fwd_hit,
    output logic [DATA_W-1:0]   fwd_data
`endif
);

    logic                         mem_acc;
    logic                         alu_acc;
    logic [REG_AW-1:0]            sel_wr;
    logic [DATA_W-1:0]            sel_wd;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic [REG_AW-1:0]            head_wr;
    logic [DATA_W-1:0]            head_wd;
    logic [DEPTH-1:0]             vld_vec;
    logic [DEPTH-1:0][REG_AW-1:0] wr_vec;

`ifdef RF_WB_FORWARD_EN
    rf_entry_t [DEPTH-1:0]        ents;
    logic [AW-1:0]                rd_ptr;
    logic [AW-1:0]                fwd_idx;
`endif

    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_acc   = alu_valid && alu_ready;
    assign sel_wr    = mem_acc ? mem_wr : alu_wr;
    assign sel_wd    = mem_acc ? mem_wd : alu_wd;

    // Writes to $0 complete the handshake but are dropped here.
    assign fifo_push = (mem_acc || alu_acc) && (sel_wr != '0);

    // The register file never stalls, so the head retires every non-empty cycle.
    assign fifo_pop  = !empty;

    assign rf_we = !empty;
    assign rf_wr = empty ? '0 : head_wr;
    assign rf_wd = empty ? '0 : head_wd;

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .push_wr (sel_wr),
        .push_wd (sel_wd),
        .pop     (fifo_pop),
        .head_wr (head_wr),
        .head_wd (head_wd),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .vld_vec (vld_vec),
        .wr_vec  (wr_vec)
`ifdef RF_WB_FORWARD_EN
        ,
        .ents    (ents),
        .rd_ptr  (rd_ptr)
`endif
    );

    // Scoreboard: includes the head while it is being presented.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_vec[i]) begin
                pend_mask[wr_vec[i]] = 1'b1;
            end
        end
    end

`ifdef RF_WB_FORWARD_EN
    // Walk oldest to youngest so the last match (the youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (fwd_rr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = rd_ptr + AW'(i);
                if (ents[fwd_idx].valid && (ents[fwd_idx].wr == fwd_rr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = ents[fwd_idx].wd;
                end
            end
        end
    end
`endif

endmodule
